lcd_timing_ctrl: RTL and testbench
==================================

Name: lcd_timing_ctrl

Overview:
- RGB-panel timing controller that sequences the pixel pipeline.
- Generates HSYNC/VSYNC/DE, the pixel_xpos/pixel_ypos/h_disp/v_disp bus consumed by the pixel generator, and a one-cycle-early data request.
- Gates the returned pixel_data onto the panel RGB pins.
- Supports start/stop only on frame boundaries.

Parameters:
- H_SYNC, 41, hsync pulse width (pclk)
- H_BACK, 2, horizontal back porch
- H_DISP, 480, active pixels per line
- H_FRONT, 2, horizontal front porch
- V_SYNC, 10, vsync pulse width (lines)
- V_BACK, 2, vertical back porch
- V_DISP, 272, active lines
- V_FRONT, 2, vertical front porch
- Derived, not overridable: H_TOTAL = sum of H params = 525; V_TOTAL = 286. All params must be ≥1 and H_TOTAL, V_TOTAL ≤ 2047.

Ports:
- lcd_pclk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- lcd_en  in  1  run request, level
- pixel_data  in  24  RGB888 from pixel generator, registered there one cycle after pixel_xpos/pixel_ypos
- pixel_xpos  out  11  x of requested pixel
- pixel_ypos  out  11  y of requested pixel
- h_disp  out  11  constant H_DISP
- v_disp  out  11  constant V_DISP
- data_req  out  1  request; leads lcd_de by exactly 1 cycle
- lcd_hs  out  1  hsync, active low
- lcd_vs  out  1  vsync, active low
- lcd_de  out  1  data enable, active high
- lcd_rgb  out  24  panel data
- frame_done  out  1  1-cycle pulse on last pclk of each frame
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Clock and reset: single clock lcd_pclk; reset rst_n asynchronous, active-low.
- Reset values: h_cnt = 0, v_cnt = 0, state = IDLE.
  - Outputs: lcd_hs = 1, lcd_vs = 1, lcd_de = 0, data_req = 0, pixel_xpos = 0, pixel_ypos = 0, lcd_rgb = 0, frame_done = 0, busy = 0.
  - h_disp and v_disp are constants, valid in reset.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt runs 0..V_TOTAL-1 and wraps.
  - Both counters advance only in RUN and DRAIN; held at 0 in IDLE.
- Decode (combinational from registered counters, forced inactive in IDLE):
  - lcd_hs = 0 when h_cnt < H_SYNC.
  - lcd_vs = 0 when v_cnt < V_SYNC.
  - HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
  - v_act = VA ≤ v_cnt < VA+V_DISP.
  - lcd_de = v_act and HA ≤ h_cnt < HA+H_DISP.
  - data_req = v_act and HA-1 ≤ h_cnt < HA+H_DISP-1.
- Positions:
  - pixel_xpos = h_cnt-(HA-1) when data_req, else 0.
  - pixel_ypos = v_cnt-VA when v_act, else 0.
  - Arithmetic is 11-bit unsigned; no underflow is possible inside the qualifying windows.
- RGB gating: lcd_rgb = pixel_data when lcd_de, else 24'h0. This gives 1-cycle alignment with the generator register.
- frame_done = 1 when h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1, in RUN or DRAIN.
- FSM:
  - IDLE → RUN when lcd_en = 1. The first active cycle has h_cnt = 0, v_cnt = 0.
  - RUN → DRAIN when lcd_en = 0.
  - DRAIN → RUN when lcd_en = 1 again, with no counter disturbance.
  - DRAIN → IDLE on the frame_done cycle. Counters reset to 0 on that edge.
  - RUN with lcd_en = 1 loops frames indefinitely.
  - lcd_en falling on the frame_done cycle in RUN: the frame completes, next state is IDLE.
- Reset mid-frame: immediate return to reset values, no partial-frame completion.

Optional Feature:
- Macro: LCD_TEST_BORDER_EN.
- When defined:
  - Extra input test_border (1 bit).
  - While test_border = 1 and lcd_de = 1: lcd_rgb = 24'hFFFFFF on the outermost active row/column (x == 0, x == H_DISP-1, y == 0, y == V_DISP-1, using the de-aligned position), else 24'h000000.
  - The de-aligned position is pixel_xpos/pixel_ypos delayed 1 cycle (one extra 22-bit register).
- When undefined: no port, no registers; lcd_rgb per Behaviour.

Decomposition:
- Package lcd_pkg holds:
  - color constants WHITE/BLACK/RED/GREEN/BLUE;
  - 11-bit position width constant;
  - state enum {IDLE, RUN, DRAIN};
  - default 480x272 timing constants.
- One natural sub-module, lcd_timing_cnt: h/v counters plus window decode. Top holds the FSM, the RGB gating and the optional border logic.

Test Plan:
- Reset asserted mid-line with lcd_en = 1 → all outputs at reset values within the same cycle. After release, first lcd_hs falling edge occurs on the 1st RUN cycle.
- lcd_en = 1 for 2 frames → period 525×286 = 150150 pclks between frame_done pulses.
  - lcd_hs low for 41 pclks per line; lcd_vs low for 10 lines.
  - lcd_de high for 480 pclks on 272 lines per frame.
- data_req/position alignment:
  - data_req rises at h_cnt = 42, with pixel_xpos = 0.
  - lcd_de rises at h_cnt = 43.
  - Last request at h_cnt = 521 has pixel_xpos = 479.
  - First active line has pixel_ypos = 0 at v_cnt = 12; last active line has pixel_ypos = 271.
- Model generator driving pixel_data = {13'b0, xpos} registered → lcd_rgb equals 0..479 in order during de; lcd_rgb = 0 outside de.
- Drop lcd_en at line 100 → busy stays high, frame finishes, busy falls after frame_done, lcd_hs stays 1.
  - Re-raise lcd_en during DRAIN → no frame gap, counters uninterrupted.
- With LCD_TEST_BORDER_EN and test_border = 1:
  - lcd_rgb = FFFFFF for all of line y = 0 and at x = 0 and x = 479 of each line.
  - lcd_rgb = 000000 at (x = 1, y = 1).

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, colour constants and default 480x272 panel timing for the LCD timing controller.
package lcd_pkg;

    localparam int POS_W = 11;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } lcd_state_t;

    localparam int DEF_H_SYNC  = 41;
    localparam int DEF_H_BACK  = 2;
    localparam int DEF_H_DISP  = 480;
    localparam int DEF_H_FRONT = 2;
    localparam int DEF_V_SYNC  = 10;
    localparam int DEF_V_BACK  = 2;
    localparam int DEF_V_DISP  = 272;
    localparam int DEF_V_FRONT = 2;

endpackage

// File: rtl/lcd_timing_cnt.sv
// Horizontal/vertical pixel counters plus the sync, active and request window decode.
module lcd_timing_cnt
    import lcd_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic             hs_win,
    output logic             vs_win,
    output logic             v_act,
    output logic             de_win,
    output logic             req_win,
    output logic             frame_last,
    output logic [POS_W-1:0] x_raw,
    output logic [POS_W-1:0] y_raw
);

    localparam logic [POS_W-1:0] H_LAST    = POS_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [POS_W-1:0] HS_END    = POS_W'(H_SYNC);
    localparam logic [POS_W-1:0] VS_END    = POS_W'(V_SYNC);
    localparam logic [POS_W-1:0] HA        = POS_W'(H_SYNC + H_BACK);
    localparam logic [POS_W-1:0] HA_END    = POS_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [POS_W-1:0] REQ_START = POS_W'(H_SYNC + H_BACK - 1);
    localparam logic [POS_W-1:0] REQ_END   = POS_W'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [POS_W-1:0] VA        = POS_W'(V_SYNC + V_BACK);
    localparam logic [POS_W-1:0] VA_END    = POS_W'(V_SYNC + V_BACK + V_DISP);
    localparam logic [POS_W-1:0] ONE       = POS_W'(1);

    logic [POS_W-1:0] h_cnt;
    logic [POS_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Counters sit at the frame origin whenever the controller is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!advance) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            // NOTE: non-blocking assignments, so v_cnt sees the pre-edge h_cnt like real flops.
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + ONE;
        end else begin
            h_cnt <= h_cnt + ONE;
        end
    end

    assign hs_win     = (h_cnt < HS_END);
    assign vs_win     = (v_cnt < VS_END);
    assign v_act      = (v_cnt >= VA) && (v_cnt < VA_END);
    assign de_win     = v_act && (h_cnt >= HA) && (h_cnt < HA_END);
    assign req_win    = v_act && (h_cnt >= REQ_START) && (h_cnt < REQ_END);
    assign frame_last = h_last && v_last;
    assign x_raw      = h_cnt - REQ_START;
    assign y_raw      = v_cnt - VA;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// RGB-panel timing controller: frame-boundary start/stop FSM, sync/DE decode, pixel request and RGB gating.
// Optional LCD_TEST_BORDER_EN adds a test_border input that replaces the picture with a white frame outline.
module lcd_timing_ctrl
    import lcd_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             lcd_en,
`ifdef LCD_TEST_BORDER_EN
    input  logic             test_border,
`endif
    input  logic [23:0]      pixel_data,
    output logic [POS_W-1:0] pixel_xpos,
    output logic [POS_W-1:0] pixel_ypos,
    output logic [POS_W-1:0] h_disp,
    output logic [POS_W-1:0] v_disp,
    output logic             data_req,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [23:0]      lcd_rgb,
    output logic             frame_done,
    output logic             busy
);

    lcd_state_t       state;
    lcd_state_t       state_next;
    logic             active;
    logic             hs_win;
    logic             vs_win;
    logic             v_act;
    logic             de_win;
    logic             req_win;
    logic             frame_last;
    logic [POS_W-1:0] x_raw;
    logic [POS_W-1:0] y_raw;

    assign h_disp = POS_W'(H_DISP);
    assign v_disp = POS_W'(V_DISP);
    assign active = (state != IDLE);

    lcd_timing_cnt #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT)
    ) u_cnt (
        .clk       (lcd_pclk),
        .rst_n     (rst_n),
        .advance   (active),
        .hs_win    (hs_win),
        .vs_win    (vs_win),
        .v_act     (v_act),
        .de_win    (de_win),
        .req_win   (req_win),
        .frame_last(frame_last),
        .x_raw     (x_raw),
        .y_raw     (y_raw)
    );

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stopping is only honoured at the end of a frame; a re-raised enable while draining resumes seamlessly.
    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (lcd_en) state_next = RUN;
            RUN:     if (!lcd_en) state_next = frame_last ? IDLE : DRAIN;
            DRAIN:   if (lcd_en) state_next = RUN;
                     else if (frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = active;
        lcd_hs     = 1'b1;
        lcd_vs     = 1'b1;
        lcd_de     = 1'b0;
        data_req   = 1'b0;
        frame_done = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        if (active) begin
            lcd_hs     = !hs_win;
            lcd_vs     = !vs_win;
            lcd_de     = de_win;
            data_req   = req_win;
            frame_done = frame_last;
            if (req_win) pixel_xpos = x_raw;
            if (v_act)   pixel_ypos = y_raw;
        end
    end

`ifdef LCD_TEST_BORDER_EN
    localparam logic [POS_W-1:0] X_LAST = POS_W'(H_DISP - 1);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_DISP - 1);

    // Request position delayed one cycle so it lines up with lcd_de.
    logic [POS_W-1:0] x_de;
    logic [POS_W-1:0] y_de;
    logic             on_border;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_de <= '0;
            y_de <= '0;
        end else begin
            x_de <= pixel_xpos;
            y_de <= pixel_ypos;
        end
    end

    assign on_border = (x_de == '0) || (x_de == X_LAST) || (y_de == '0) || (y_de == Y_LAST);

    always_comb begin
        lcd_rgb = BLACK;
        if (lcd_de) lcd_rgb = test_border ? (on_border ? WHITE : BLACK) : pixel_data;
    end
`else
    always_comb begin
        lcd_rgb = BLACK;
        if (lcd_de) lcd_rgb = pixel_data;
    end
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench: full-size panel for reset and line alignment, a small-geometry instance for frame-level behaviour.
module tb_lcd_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Default 480x272 instance
    logic        rst_n_a = 1'b0;
    logic        en_a    = 1'b1;
    logic        tb_a    = 1'b0;
    logic [23:0] pd_a    = '0;
    logic [10:0] xpos_a, ypos_a, hd_a, vd_a;
    logic        req_a, hs_a, vs_a, de_a, fd_a, busy_a;
    logic [23:0] rgb_a;

    // Small geometry: H 3/2/8/2 (total 15), V 2/1/4/1 (total 8), frame = 120 pclks
    logic        rst_n_s = 1'b0;
    logic        en_s    = 1'b0;
    logic        tb_s    = 1'b0;
    logic [23:0] pd_s    = '0;
    logic [10:0] xpos_s, ypos_s, hd_s, vd_s;
    logic        req_s, hs_s, vs_s, de_s, fd_s, busy_s;
    logic [23:0] rgb_s;

    // Model pixel generator: registers its x position, as the real one does
    always @(posedge clk) pd_a <= {13'b0, xpos_a};
    always @(posedge clk) pd_s <= {13'b0, xpos_s};

    lcd_timing_ctrl dut_a (
        .lcd_pclk   (clk),
        .rst_n      (rst_n_a),
        .lcd_en     (en_a),
`ifdef LCD_TEST_BORDER_EN
        .test_border(tb_a),
`endif
        .pixel_data (pd_a),
        .pixel_xpos (xpos_a),
        .pixel_ypos (ypos_a),
        .h_disp     (hd_a),
        .v_disp     (vd_a),
        .data_req   (req_a),
        .lcd_hs     (hs_a),
        .lcd_vs     (vs_a),
        .lcd_de     (de_a),
        .lcd_rgb    (rgb_a),
        .frame_done (fd_a),
        .busy       (busy_a)
    );

    lcd_timing_ctrl #(
        .H_SYNC(3), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
    ) dut_s (
        .lcd_pclk   (clk),
        .rst_n      (rst_n_s),
        .lcd_en     (en_s),
`ifdef LCD_TEST_BORDER_EN
        .test_border(tb_s),
`endif
        .pixel_data (pd_s),
        .pixel_xpos (xpos_s),
        .pixel_ypos (ypos_s),
        .h_disp     (hd_s),
        .v_disp     (vd_s),
        .data_req   (req_s),
        .lcd_hs     (hs_s),
        .lcd_vs     (vs_s),
        .lcd_de     (de_s),
        .lcd_rgb    (rgb_s),
        .frame_done (fd_s),
        .busy       (busy_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vec++;
        if ({hs_a, vs_a, de_a, req_a, fd_a, busy_a} !== 6'b110000 || xpos_a !== 11'd0 ||
            ypos_a !== 11'd0 || rgb_a !== 24'h0) begin
            errs++;
            $display("FAIL reset_values: hs/vs/de/req/fd/busy=%b xpos=%0d ypos=%0d rgb=%h, expected 110000 0 0 0",
                     {hs_a, vs_a, de_a, req_a, fd_a, busy_a}, xpos_a, ypos_a, rgb_a);
        end
        vec++;
        if (hd_a !== 11'd480 || vd_a !== 11'd272) begin
            errs++;
            $display("FAIL disp_consts: h_disp=%0d v_disp=%0d, expected 480 272", hd_a, vd_a);
        end
        rst_n_a = 1'b1;
        #1;
        expect_bit("idle_hs_high", hs_a, 1'b1);
        expect_bit("idle_not_busy", busy_a, 1'b0);
        tick();
        expect_bit("first_run_hs_low", hs_a, 1'b0);
        expect_bit("first_run_vs_low", vs_a, 1'b0);
        expect_bit("first_run_busy", busy_a, 1'b1);
    endtask

    // Entered on the first RUN cycle (h_cnt = 0, v_cnt = 0)
    task automatic test_default_timing();
        int hs_low  = 0;
        int de_cnt  = 0;
        int rgb_bad = 0;
        int exp_x   = 0;
        for (int k = 0; k < 13 * 525 + 200; k++) begin
            if (k < 525 && !hs_a) hs_low++;
            if (k / 525 == 12) begin
                if (de_a) begin
                    if (rgb_a !== 24'(exp_x)) rgb_bad++;
                    exp_x++;
                    de_cnt++;
                end else if (rgb_a !== 24'h0) begin
                    rgb_bad++;
                end
            end
            case (k)
                40:            expect_bit("hs_low_h40", hs_a, 1'b0);
                41:            expect_bit("hs_high_h41", hs_a, 1'b1);
                9 * 525 + 100: expect_bit("vs_low_line9", vs_a, 1'b0);
                10 * 525:      expect_bit("vs_high_line10", vs_a, 1'b1);
                11 * 525 + 42: expect_bit("no_req_line11", req_a, 1'b0);
                12 * 525 + 41: expect_bit("no_req_h41", req_a, 1'b0);
                12 * 525 + 42: begin
                    expect_bit("req_rise_h42", req_a, 1'b1);
                    expect_bit("de_low_h42", de_a, 1'b0);
                    expect_int("xpos_h42", int'(xpos_a), 0);
                    expect_int("ypos_line12", int'(ypos_a), 0);
                end
                12 * 525 + 43: begin
                    expect_bit("de_rise_h43", de_a, 1'b1);
                    expect_int("xpos_h43", int'(xpos_a), 1);
                end
                12 * 525 + 521: begin
                    expect_bit("req_last_h521", req_a, 1'b1);
                    expect_int("xpos_h521", int'(xpos_a), 479);
                end
                12 * 525 + 522: begin
                    expect_bit("req_fall_h522", req_a, 1'b0);
                    expect_bit("de_h522", de_a, 1'b1);
                    expect_int("rgb_h522", int'(rgb_a), 479);
                end
                12 * 525 + 523: expect_bit("de_fall_h523", de_a, 1'b0);
                13 * 525 + 199: begin
                    expect_int("ypos_line13", int'(ypos_a), 1);
                    expect_int("xpos_line13_h199", int'(xpos_a), 157);
                end
                default: ;
            endcase
            tick();
        end
        expect_int("hs_low_count", hs_low, 41);
        expect_int("de_count_line12", de_cnt, 480);
        expect_int("rgb_sequence_errors", rgb_bad, 0);
    endtask

    // Entered mid active line 13 (h_cnt = 200)
    task automatic test_reset_midframe();
        expect_bit("de_before_reset", de_a, 1'b1);
        #2;
        rst_n_a = 1'b0;
        #1;
        vec++;
        if ({hs_a, vs_a, de_a, req_a, fd_a, busy_a} !== 6'b110000 || xpos_a !== 11'd0 ||
            ypos_a !== 11'd0 || rgb_a !== 24'h0) begin
            errs++;
            $display("FAIL midframe_reset: hs/vs/de/req/fd/busy=%b xpos=%0d ypos=%0d rgb=%h, expected 110000 0 0 0",
                     {hs_a, vs_a, de_a, req_a, fd_a, busy_a}, xpos_a, ypos_a, rgb_a);
        end
    endtask

    task automatic test_frame_period();
        int fd1 = -1;
        int fd2 = -1;
        int hs_low = 0;
        int vs_low = 0;
        int de_cnt = 0;
        int busy_drop = 0;
        rst_n_s = 1'b1;
        en_s    = 1'b1;
        tick();
        for (int k = 0; k < 260; k++) begin
            if (fd_s) begin
                if (fd1 < 0) fd1 = k;
                else if (fd2 < 0) fd2 = k;
            end
            if (k < 120) begin
                if (!hs_s) hs_low++;
                if (!vs_s) vs_low++;
                if (de_s) de_cnt++;
            end
            if (!busy_s) busy_drop++;
            if (k == 3 * 15 + 4) begin
                expect_bit("s_req_first", req_s, 1'b1);
                expect_int("s_xpos_first", int'(xpos_s), 0);
            end
            if (k == 6 * 15 + 11) begin
                expect_int("s_xpos_last", int'(xpos_s), 7);
                expect_int("s_ypos_last", int'(ypos_s), 3);
            end
            tick();
        end
        expect_int("frame_done_first", fd1, 119);
        expect_int("frame_done_period", fd2 - fd1, 120);
        expect_int("s_hs_low_frame", hs_low, 24);
        expect_int("s_vs_low_frame", vs_low, 30);
        expect_int("s_de_frame", de_cnt, 32);
        expect_int("s_busy_drops", busy_drop, 0);
    endtask

    // Steps to the first cycle of the next frame; a missing frame_done counts as a failure
    task automatic sync_frame();
        int found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (fd_s) found = 1;
            tick();
        end
        expect_int("frame_done_seen", found, 1);
    endtask

    task automatic test_drain();
        int fd_at = -1;
        int busy_drop = 0;
        int de_cnt = 0;
        int hs_after = 0;
        int busy_after = 0;
        sync_frame();
        for (int fk = 0; fk < 140; fk++) begin
            if (fk == 4 * 15) en_s = 1'b0;
            if (fk < 120) begin
                if (!busy_s) busy_drop++;
                if (de_s) de_cnt++;
            end else begin
                if (!hs_s) hs_after++;
                if (busy_s) busy_after++;
            end
            if (fd_s && fd_at < 0) fd_at = fk;
            tick();
        end
        expect_int("drain_busy_drops", busy_drop, 0);
        expect_int("drain_de_count", de_cnt, 32);
        expect_int("drain_frame_done", fd_at, 119);
        expect_int("idle_hs_low_cycles", hs_after, 0);
        expect_int("idle_busy_cycles", busy_after, 0);
    endtask

    task automatic test_reraise();
        int fd1 = -1;
        int fd2 = -1;
        int busy_drop = 0;
        en_s = 1'b1;
        tick();
        for (int fk = 0; fk < 250; fk++) begin
            if (fk == 50) en_s = 1'b0;
            if (fk == 60) en_s = 1'b1;
            if (!busy_s) busy_drop++;
            if (fd_s) begin
                if (fd1 < 0) fd1 = fk;
                else if (fd2 < 0) fd2 = fk;
            end
            if (fk == 4 * 15 + 5) begin
                expect_bit("reraise_de", de_s, 1'b1);
                expect_int("reraise_ypos", int'(ypos_s), 1);
                expect_int("reraise_rgb", int'(rgb_s), 0);
            end
            tick();
        end
        expect_int("reraise_busy_drops", busy_drop, 0);
        expect_int("reraise_fd1", fd1, 119);
        expect_int("reraise_fd2", fd2, 239);
    endtask

    task automatic test_en_fall_on_done();
        int found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (fd_s) found = 1;
            else tick();
        end
        expect_int("done_reached", found, 1);
        expect_bit("done_cycle_busy", busy_s, 1'b1);
        en_s = 1'b0;
        tick();
        expect_bit("en_fall_on_done_idle", busy_s, 1'b0);
        expect_bit("en_fall_on_done_hs", hs_s, 1'b1);
    endtask

`ifdef LCD_TEST_BORDER_EN
    task automatic test_border();
        int row_white = 0;
        int last_row_white = 0;
        tb_s = 1'b1;
        en_s = 1'b1;
        tick();
        for (int fk = 0; fk < 120; fk++) begin
            if (fk / 15 == 3 && de_s && rgb_s === 24'hFFFFFF) row_white++;
            if (fk / 15 == 6 && de_s && rgb_s === 24'hFFFFFF) last_row_white++;
            case (fk)
                4 * 15 + 5:  expect_int("border_x0_y1", int'(rgb_s), 24'hFFFFFF);
                4 * 15 + 6:  expect_int("border_x1_y1", int'(rgb_s), 0);
                4 * 15 + 12: expect_int("border_x7_y1", int'(rgb_s), 24'hFFFFFF);
                4 * 15 + 13: expect_int("border_outside_de", int'(rgb_s), 0);
                default: ;
            endcase
            tick();
        end
        expect_int("border_row0_white", row_white, 8);
        expect_int("border_row3_white", last_row_white, 8);
        tb_s = 1'b0;
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_default_timing();
        test_reset_midframe();
        test_frame_period();
        test_drain();
        test_reraise();
        test_en_fall_on_done();
`ifdef LCD_TEST_BORDER_EN
        test_border();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
